pid_ctrl: RTL and testbench

PID_CTRL -- requirements
Module: pid_ctrl

---
 rtl/pid_ctrl.sv | 124 ++++++++++++
 tb/tb_pid_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pid_ctrl.sv
// PID heading controller: turns a saturated heading-error stream into
// registered left/right wheel speed commands around a forward speed.
module pid_ctrl #(
    parameter logic [3:0] P_COEFF = 4'd6,
    parameter logic [4:0] D_COEFF = 5'd14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               moving,
    input  logic               err_vld,
    input  logic signed [11:0] error,
    input  logic        [9:0]  frwrd,
    output logic signed [10:0] lft_spd,
    output logic signed [10:0] rght_spd
);

    logic signed [9:0]  errSat;
    logic signed [9:0]  errReg_q, errReg_d;
    logic signed [9:0]  prevErr_q, prevErr_d;
    logic signed [15:0] integ_q, integ_d;
    logic signed [15:0] integSum;
    logic               integOvf;
    logic signed [10:0] errDiff;
    logic signed [6:0]  diffSat;
    logic signed [13:0] pTerm, iTerm, dTerm, pid;
    logic signed [10:0] pidScaled;
    logic signed [11:0] lftSum, rghtSum;
    logic signed [10:0] lftSat, rghtSat;
    logic signed [10:0] lftSpd_d, rghtSpd_d;

    // Clamp the raw 12-bit error into the 10-bit range the loop works in.
    always_comb begin
        if (error > 12'sd511) begin
            errSat = 10'sd511;
        end else if (error < -12'sd512) begin
            errSat = -10'sd512;
        end else begin
            errSat = error[9:0];
        end
    end

    // Candidate integrator sum and signed-overflow detect (same-sign operands, sign flips).
    always_comb begin
        integSum = integ_q + {{6{errSat[9]}}, errSat};
        integOvf = (integ_q[15] == errSat[9]) && (integSum[15] != integ_q[15]);
    end

    // P, I and D terms, all as 14-bit signed quantities, plus their sum.
    always_comb begin
        pTerm   = {{4{errReg_q[9]}}, errReg_q} * {10'd0, P_COEFF};
        iTerm   = {{4{integ_q[15]}}, integ_q[15:6]};
        errDiff = {errReg_q[9], errReg_q} - {prevErr_q[9], prevErr_q};
        if (errDiff > 11'sd63) begin
            diffSat = 7'sd63;
        end else if (errDiff < -11'sd64) begin
            diffSat = -7'sd64;
        end else begin
            diffSat = errDiff[6:0];
        end
        dTerm     = {{7{diffSat[6]}}, diffSat} * {9'd0, D_COEFF};
        pid       = pTerm + iTerm + dTerm;
        pidScaled = pid[13:3];
    end

    // Steer around the forward speed and clamp each wheel command to 11 bits.
    always_comb begin
        lftSum  = {2'b00, frwrd} + {pidScaled[10], pidScaled};
        rghtSum = {2'b00, frwrd} - {pidScaled[10], pidScaled};
        if (lftSum > 12'sd1023) begin
            lftSat = 11'sd1023;
        end else if (lftSum < -12'sd1024) begin
            lftSat = -11'sd1024;
        end else begin
            lftSat = lftSum[10:0];
        end
        if (rghtSum > 12'sd1023) begin
            rghtSat = 11'sd1023;
        end else if (rghtSum < -12'sd1024) begin
            rghtSat = -11'sd1024;
        end else begin
            rghtSat = rghtSum[10:0];
        end
    end

    // Next-state selection: a stopped robot clears the integrator and zeroes the wheels.
    always_comb begin
        errReg_d  = errReg_q;
        prevErr_d = prevErr_q;
        integ_d   = integ_q;
        lftSpd_d  = 11'sd0;
        rghtSpd_d = 11'sd0;
        if (err_vld) begin
            errReg_d  = errSat;
            prevErr_d = errReg_q;
        end
        if (!moving) begin
            integ_d = 16'sd0;
        end else if (err_vld && !integOvf) begin
            integ_d = integSum;
        end
        if (moving) begin
            lftSpd_d  = lftSat;
            rghtSpd_d = rghtSat;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            errReg_q  <= 10'sd0;
            prevErr_q <= 10'sd0;
            integ_q   <= 16'sd0;
            lft_spd   <= 11'sd0;
            rght_spd  <= 11'sd0;
        end else begin
            errReg_q  <= errReg_d;
            prevErr_q <= prevErr_d;
            integ_q   <= integ_d;
            lft_spd   <= lftSpd_d;
            rght_spd  <= rghtSpd_d;
        end
    end

endmodule

// File: tb/tb_pid_ctrl.sv
// Testbench for pid_ctrl: an integer reference model predicts every output
// cycle into a queue, a monitor pops and compares, and directed checks pin
// down the worked examples.
module tb_pid_ctrl;

    localparam int P_GAIN = 6;
    localparam int D_GAIN = 14;

    logic               clk = 1'b0;
    logic               rst;
    logic               moving;
    logic               err_vld;
    logic signed [11:0] error;
    logic        [9:0]  frwrd;
    logic signed [10:0] lft_spd;
    logic signed [10:0] rght_spd;

    typedef struct {
        logic signed [10:0] l;
        logic signed [10:0] r;
    } exp_t;

    exp_t expQ[$];
    exp_t modelExp;
    exp_t gotExp;

    int checks = 0;
    int errors = 0;

    int mEr  = 0;
    int mPe  = 0;
    int mInt = 0;
    int mIn;
    int mPid;
    int mScaled;
    int mSum;

    pid_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .moving   (moving),
        .err_vld  (err_vld),
        .error    (error),
        .frwrd    (frwrd),
        .lft_spd  (lft_spd),
        .rght_spd (rght_spd)
    );

    always #5 clk = ~clk;

    function automatic int sat(input int x, input int lo, input int hi);
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    // Reference model: predicts the outputs registered on this edge, then advances its state.
    always @(posedge clk) begin
        if (rst) begin
            modelExp.l = 11'sd0;
            modelExp.r = 11'sd0;
            mEr  = 0;
            mPe  = 0;
            mInt = 0;
        end else begin
            mPid    = mEr * P_GAIN + (mInt >>> 6) + sat(mEr - mPe, -64, 63) * D_GAIN;
            mScaled = mPid >>> 3;
            if (moving) begin
                modelExp.l = 11'(sat(int'(frwrd) + mScaled, -1024, 1023));
                modelExp.r = 11'(sat(int'(frwrd) - mScaled, -1024, 1023));
            end else begin
                modelExp.l = 11'sd0;
                modelExp.r = 11'sd0;
            end
            mIn = $signed(error);
            mIn = sat(mIn, -512, 511);
            if (!moving) begin
                mInt = 0;
            end else if (err_vld) begin
                mSum = mInt + mIn;
                if (mSum <= 32767 && mSum >= -32768) mInt = mSum;
            end
            if (err_vld) begin
                mPe = mEr;
                mEr = mIn;
            end
        end
        expQ.push_back(modelExp);
    end

    // Monitor: compares each registered output against the oldest prediction.
    always @(posedge clk) begin
        #1;
        if (expQ.size() > 0) begin
            gotExp = expQ.pop_front();
            checks++;
            if (lft_spd !== gotExp.l || rght_spd !== gotExp.r) begin
                errors++;
                $display("[TB] FAIL scoreboard t=%0t got lft=%0d rght=%0d, expected lft=%0d rght=%0d",
                         $time, lft_spd, rght_spd, gotExp.l, gotExp.r);
            end
        end
    end

    task automatic applyStimulus(input logic m, input logic v,
                                 input logic [11:0] e, input logic [9:0] f);
        @(negedge clk);
        moving  = m;
        err_vld = v;
        error   = e;
        frwrd   = f;
    endtask

    task automatic checkOutput(input string name,
                               input logic signed [10:0] expL,
                               input logic signed [10:0] expR);
        @(negedge clk);
        checks++;
        if (lft_spd !== expL || rght_spd !== expR) begin
            errors++;
            $display("[TB] FAIL %s got lft=%0d rght=%0d, expected lft=%0d rght=%0d",
                     name, lft_spd, rght_spd, expL, expR);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst     = 1'b1;
        moving  = 1'b0;
        err_vld = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog expired at t=%0t, expected completion earlier", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst     = 1'b1;
        moving  = 1'b1;
        err_vld = 1'b1;
        error   = 12'sd0;
        frwrd   = 10'd0;
        repeat (2) @(negedge clk);
        checkOutput("reset", 11'sd0, 11'sd0);
        rst = 1'b0;

        // Zero error tracks the forward speed
        applyStimulus(1'b1, 1'b1, 12'd0, 10'd512);
        applyStimulus(1'b1, 1'b0, 12'd0, 10'd512);
        applyStimulus(1'b1, 1'b1, 12'd0, 10'd512);
        applyStimulus(1'b1, 1'b0, 12'd0, 10'd512);
        checkOutput("zero_err", 11'sd512, 11'sd512);

        // Step error, two pulses
        doReset();
        applyStimulus(1'b1, 1'b1, 12'd100, 10'd512);
        applyStimulus(1'b1, 1'b0, 12'd100, 10'd512);
        checkOutput("step1", 11'sd697, 11'sd327);
        applyStimulus(1'b1, 1'b1, 12'd100, 10'd512);
        applyStimulus(1'b1, 1'b0, 12'd100, 10'd512);
        checkOutput("step2", 11'sd587, 11'sd437);

        // Positive and negative error saturation
        doReset();
        applyStimulus(1'b1, 1'b1, 12'h7FF, 10'd1023);
        applyStimulus(1'b1, 1'b0, 12'h7FF, 10'd1023);
        checkOutput("sat_pos", 11'sd1023, 11'sd529);
        doReset();
        applyStimulus(1'b1, 1'b1, 12'h800, 10'd1023);
        applyStimulus(1'b1, 1'b0, 12'h800, 10'd1023);
        checkOutput("sat_neg", 11'sd526, 11'sd1023);

        // Integrator overflow holds at 32704 (I_term 511)
        doReset();
        for (int i = 0; i < 65; i++) applyStimulus(1'b1, 1'b1, 12'd511, 10'd0);
        applyStimulus(1'b1, 1'b0, 12'd511, 10'd0);
        applyStimulus(1'b1, 1'b0, 12'd511, 10'd0);
        checkOutput("int_ovf", 11'sd447, -11'sd447);

        // Dropping moving zeroes outputs and the integrator
        applyStimulus(1'b0, 1'b0, 12'd511, 10'd300);
        checkOutput("stop", 11'sd0, 11'sd0);
        applyStimulus(1'b1, 1'b1, 12'd0, 10'd300);
        applyStimulus(1'b1, 1'b1, 12'd0, 10'd300);
        applyStimulus(1'b1, 1'b0, 12'd0, 10'd300);
        checkOutput("restart", 11'sd300, 11'sd300);

        // Error changes without err_vld leave outputs untouched
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0, 12'($urandom), 10'd300);
            checkOutput("vld_gate", 11'sd300, 11'sd300);
        end

        // Randomized traffic, including resets and moving drops with err_vld
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            rst     = ($urandom_range(0, 59) == 0);
            moving  = ($urandom_range(0, 9) != 0);
            err_vld = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 1) == 0) begin
                error = 12'($urandom);
            end else begin
                error = 12'($urandom_range(0, 255)) - 12'd128;
            end
            if ($urandom_range(0, 3) == 0) begin
                frwrd = 10'd1023;
            end else begin
                frwrd = 10'($urandom);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
